// File: rtl/phy_pkg.sv
// Shared PHY constants and types for the serial lane: symbol width, COM symbol,
// and the receive aligner state encoding (also reused by the TX side).
package phy_pkg;

  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] COM_SYMBOL = 8'hBC;
  localparam int COM_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } rx_state_e;

  typedef logic [2:0] bit_cnt_t;

  localparam bit_cnt_t BIT_CNT_LAST = 3'd7;

endpackage

// File: rtl/serial_parallel_rx_if.sv
// Serial lane in, parallel byte stream out; slave side is the receiver,
// master side is whoever feeds the lane and consumes the bytes.
interface serial_parallel_rx_if #(
  parameter int WIDTH = phy_pkg::WIDTH
);

  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             idle_byte;
  logic             valido;

  modport master (
    output data_in,
    input  data_out,
    input  data_valid,
    input  idle_byte,
    input  valido
  );

  modport slave (
    input  data_in,
    output data_out,
    output data_valid,
    output idle_byte,
    output valido
  );

endinterface

// File: rtl/com_aligner.sv
// Byte-boundary aligner: hunts for COM bit by bit, confirms COM_COUNT aligned
// COMs, then stays ACTIVE until reset. Provides the byte boundary strobe.
module com_aligner
  import phy_pkg::*;
#(
  parameter int COM_COUNT = COM_COUNT_DEFAULT
) (
  input  logic clk32f,
  input  logic reset,
  input  logic com_match_i,
  output logic boundary_o,
  output logic active_o
);

  localparam int CW = (COM_COUNT < 2) ? 1 : $clog2(COM_COUNT + 1);

  if (COM_COUNT < 1) begin : g_bad_count
    $error("com_aligner: COM_COUNT must be >= 1");
  end

  rx_state_e       state_q, state_d;
  bit_cnt_t        bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   com_cnt_q, com_cnt_d;
  logic [CW-1:0]   com_cnt_inc;
  logic            boundary;

  assign boundary = (bit_cnt_q == BIT_CNT_LAST);

  always_ff @(posedge clk32f) begin
    if (reset) begin
      state_q   <= SEARCH;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    com_cnt_d   = com_cnt_q;
    com_cnt_inc = com_cnt_q + CW'(1);

    unique case (state_q)
      SEARCH: begin
        // Forcing bit_cnt to 0 here makes the next boundary land 8 bits later.
        if (com_match_i) begin
          bit_cnt_d = '0;
          com_cnt_d = CW'(1);
          state_d   = (COM_COUNT == 1) ? ACTIVE : LOCKING;
        end
      end
      LOCKING: begin
        if (boundary) begin
          if (com_match_i) begin
            com_cnt_d = com_cnt_inc;
            if (com_cnt_inc == CW'(COM_COUNT)) begin
              state_d = ACTIVE;
            end
          end else begin
            state_d   = SEARCH;
            com_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        state_d = ACTIVE;
      end
      default: begin
        state_d   = SEARCH;
        com_cnt_d = '0;
      end
    endcase
  end

  assign boundary_o = boundary;
  assign active_o   = (state_q == ACTIVE);

endmodule

// File: rtl/serial_parallel_rx.sv
// Receive serial-to-parallel converter: MSB-first shift register, COM-based
// alignment via com_aligner, registered byte/pulse outputs once the link is active.
module serial_parallel_rx #(
  parameter int               WIDTH      = phy_pkg::WIDTH,
  parameter logic [WIDTH-1:0] COM_SYMBOL = WIDTH'(phy_pkg::COM_SYMBOL),
  parameter int               COM_COUNT  = phy_pkg::COM_COUNT_DEFAULT
) (
  input  logic                clk32f,
  input  logic                reset,
  serial_parallel_rx_if.slave rx
);

  // The oldest bit is shifted out when nxt is formed, so only WIDTH-1 bits are kept.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [WIDTH-1:0] nxt;
  logic             com_match;
  logic             boundary;
  logic             active;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             idle_byte_q, idle_byte_d;

  assign nxt       = {shift_q, rx.data_in};
  assign shift_d   = nxt[WIDTH-2:0];
  assign com_match = (nxt == COM_SYMBOL);

  com_aligner #(
    .COM_COUNT (COM_COUNT)
  ) u_aligner (
    .clk32f      (clk32f),
    .reset       (reset),
    .com_match_i (com_match),
    .boundary_o  (boundary),
    .active_o    (active)
  );

  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    idle_byte_d  = 1'b0;
    if (active && boundary) begin
      data_out_d   = nxt;
      data_valid_d = !com_match;
      idle_byte_d  = com_match;
    end
  end

  always_ff @(posedge clk32f) begin
    if (reset) begin
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      idle_byte_q  <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      idle_byte_q  <= idle_byte_d;
    end
  end

  assign rx.data_out   = data_out_q;
  assign rx.data_valid = data_valid_q;
  assign rx.idle_byte  = idle_byte_q;
  assign rx.valido     = active;

endmodule
